// File: rtl/arp_data_tx.sv
// Byte-serial Ethernet II + ARP frame generator with a valid/ready byte output.
// Optional ARP_PAD_EN: zero-pad the frame to the 60-byte Ethernet minimum.
module arp_data_tx #(
    parameter logic [15:0] ETH_TYPE_ARP = 16'h0806,
    parameter logic [15:0] HTYPE        = 16'h0001,
    parameter logic [15:0] PTYPE        = 16'h0800,
    parameter logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        oper_req,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [47:0] target_mac,
    input  logic [31:0] target_ip,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_last,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    // Output handshake: a beat transfers on a rising edge where data_valid and
    // data_ready are both high; while data_valid & !data_ready the byte,
    // data_valid and data_last are held unchanged.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef ARP_PAD_EN
        , PAD = 2'd2
`endif
    } state_t;

`ifdef ARP_PAD_EN
    localparam logic [5:0] LAST_IDX = 6'd59;
`else
    localparam logic [5:0] LAST_IDX = 6'd41;
`endif

    state_t      state_q;
    logic [5:0]  byte_cnt_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        data_last_q;
    logic        busy_q;
    logic        pending_q;

    // Latched copy (overwritten by every start) and working copy (in-flight frame).
    logic        pend_oper_q;
    logic [47:0] pend_lmac_q;
    logic [31:0] pend_lip_q;
    logic [47:0] pend_tmac_q;
    logic [31:0] pend_tip_q;
    logic        wrk_oper_q;
    logic [47:0] wrk_lmac_q;
    logic [31:0] wrk_lip_q;
    logic [47:0] wrk_tmac_q;
    logic [31:0] wrk_tip_q;

    function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic oper,
                                              input logic [47:0] lmac, input logic [31:0] lip,
                                              input logic [47:0] tmac, input logic [31:0] tip);
        logic [335:0] frame;
        frame = {oper ? BCAST_MAC : tmac, lmac, ETH_TYPE_ARP, HTYPE, PTYPE, 8'h06, 8'h04,
                 oper ? 16'h0001 : 16'h0002, lmac, lip, oper ? 48'h0 : tmac, tip};
        if (idx > 6'd41) begin
            return 8'h00;
        end
        frame = frame << {idx, 3'b000};
        return frame[335:328];
    endfunction

    logic [5:0] cnt_inc_d;
    logic [7:0] first_in_d;
    logic [7:0] first_pend_d;
    logic [7:0] next_byte_d;

    assign cnt_inc_d    = byte_cnt_q + 6'd1;
    assign first_in_d   = frame_byte(6'd0, oper_req, local_mac, local_ip, target_mac, target_ip);
    assign first_pend_d = frame_byte(6'd0, pend_oper_q, pend_lmac_q, pend_lip_q, pend_tmac_q, pend_tip_q);
    assign next_byte_d  = frame_byte(cnt_inc_d, wrk_oper_q, wrk_lmac_q, wrk_lip_q, wrk_tmac_q, wrk_tip_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 6'd0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            pend_oper_q  <= 1'b0;
            pend_lmac_q  <= 48'h0;
            pend_lip_q   <= 32'h0;
            pend_tmac_q  <= 48'h0;
            pend_tip_q   <= 32'h0;
            wrk_oper_q   <= 1'b0;
            wrk_lmac_q   <= 48'h0;
            wrk_lip_q    <= 32'h0;
            wrk_tmac_q   <= 48'h0;
            wrk_tip_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pend_oper_q  <= oper_req;
                        pend_lmac_q  <= local_mac;
                        pend_lip_q   <= local_ip;
                        pend_tmac_q  <= target_mac;
                        pend_tip_q   <= target_ip;
                        wrk_oper_q   <= oper_req;
                        wrk_lmac_q   <= local_mac;
                        wrk_lip_q    <= local_ip;
                        wrk_tmac_q   <= target_mac;
                        wrk_tip_q    <= target_ip;
                        pending_q    <= 1'b0;
                        byte_cnt_q   <= 6'd0;
                        data_out_q   <= first_in_d;
                        data_valid_q <= 1'b1;
                        data_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end else if (pending_q) begin
                        wrk_oper_q   <= pend_oper_q;
                        wrk_lmac_q   <= pend_lmac_q;
                        wrk_lip_q    <= pend_lip_q;
                        wrk_tmac_q   <= pend_tmac_q;
                        wrk_tip_q    <= pend_tip_q;
                        pending_q    <= 1'b0;
                        byte_cnt_q   <= 6'd0;
                        data_out_q   <= first_pend_d;
                        data_valid_q <= 1'b1;
                        data_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                default: begin
                    if (start) begin
                        pend_oper_q <= oper_req;
                        pend_lmac_q <= local_mac;
                        pend_lip_q  <= local_ip;
                        pend_tmac_q <= target_mac;
                        pend_tip_q  <= target_ip;
                        pending_q   <= 1'b1;
                    end
                    if (data_valid_q && data_ready) begin
                        if (byte_cnt_q == LAST_IDX) begin
                            state_q      <= IDLE;
                            byte_cnt_q   <= 6'd0;
                            data_out_q   <= 8'h00;
                            data_valid_q <= 1'b0;
                            data_last_q  <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            byte_cnt_q  <= cnt_inc_d;
                            data_out_q  <= next_byte_d;
                            data_last_q <= (cnt_inc_d == LAST_IDX);
`ifdef ARP_PAD_EN
                            if (byte_cnt_q == 6'd41) begin
                                state_q <= PAD;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_last  = data_last_q;
    assign busy       = busy_q;
    assign fsm_state  = state_q;

endmodule
